// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package mul_pkg;

    localparam int unsigned MulXlen = 64;
    localparam int unsigned CntW    = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/bit_Adder.sv
// Plain ripple-style W-bit adder with carry in/out; chained twice for the 128-bit accumulate.
module bit_Adder #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/shift_add_mul.sv
// Unsigned XLEN x XLEN -> 2*XLEN multiplier, one multiplier bit per cycle.
// SHIFT_ADD_MUL_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are all zero.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int unsigned XLEN = MulXlen
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product_lo,
    output logic [XLEN-1:0] product_hi
);

    state_e              state_q, state_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplr_q, mplr_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     prod_lo_q, prod_lo_d;
    logic [XLEN-1:0]     prod_hi_q, prod_hi_d;

    logic [2*XLEN-1:0]   sum;
    logic                carry_lo;
    logic                unused_carry;
    logic [XLEN-1:0]     mplr_shift;
    logic                run_exit;

    bit_Adder #(.W(XLEN)) u_add_lo (
        .a    (mcand_q[XLEN-1:0]),
        .b    (acc_q[XLEN-1:0]),
        .cin  (1'b0),
        .sum  (sum[XLEN-1:0]),
        .cout (carry_lo)
    );

    bit_Adder #(.W(XLEN)) u_add_hi (
        .a    (mcand_q[2*XLEN-1:XLEN]),
        .b    (acc_q[2*XLEN-1:XLEN]),
        .cin  (carry_lo),
        .sum  (sum[2*XLEN-1:XLEN]),
        .cout (unused_carry)
    );

    assign mplr_shift = mplr_q >> 1;

`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
    assign run_exit = (cnt_q == {CntW{1'b1}}) || (mplr_shift == '0);
`else
    assign run_exit = (cnt_q == {CntW{1'b1}});
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        prod_lo_d = prod_lo_q;
        prod_hi_d = prod_hi_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d = {{XLEN{1'b0}}, a};
                    mplr_d  = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (mplr_q[0]) begin
                    acc_d = sum;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_shift;
                cnt_d   = cnt_q + CntW'(1);
                if (run_exit) begin
                    // Capture includes this cycle's partial product.
                    prod_lo_d = acc_d[XLEN-1:0];
                    prod_hi_d = acc_d[2*XLEN-1:XLEN];
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            prod_lo_q <= '0;
            prod_hi_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            prod_lo_q <= prod_lo_d;
            prod_hi_q <= prod_hi_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product_lo = prod_lo_q;
    assign product_hi = prod_hi_q;

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand width; only 64 supported.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  XLEN  multiplicand, unsigned.
REQ-006 SHALL have port b  input  XLEN  multiplier, unsigned.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port product_lo  output  XLEN  low half of a*b.
REQ-010 SHALL have port product_hi  output  XLEN  high half of a*b.

Function
REQ-011 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-012 SHALL, in IDLE with start=1, capture a into a 128-bit zero-extended multiplicand register, capture b into the multiplier register, clear the 128-bit accumulator and the 6-bit step counter, and enter RUN.
REQ-013 SHALL, in each RUN cycle: add the multiplicand to the accumulator if multiplier[0]=1, else leave it unchanged; shift the multiplicand left 1; shift the multiplier right 1; increment the counter.
REQ-014 SHALL leave RUN for DONE on the edge performing the 64th step (counter value 63 before increment).
REQ-015 SHALL compute the 128-bit sum as two 64-bit adders chained low cout to high cin, low cin=0; final carry discarded.
REQ-016 SHALL load product_lo/product_hi from the accumulator on the edge entering DONE and hold them until the next entry into DONE.
REQ-017 SHALL assert done only while in DONE, for exactly one cycle; DONE returns to IDLE unconditionally.
REQ-018 SHALL ignore start in RUN and DONE (no restart, no operand recapture).
REQ-019 SHALL, without REQ-026, give fixed latency: done high 64 rising edges after the edge sampling start; a zero operand does not shorten it.
REQ-020 SHALL accept a new start in the IDLE cycle directly following DONE (back-to-back throughput 66 cycles).

Reset
REQ-021 SHALL, on rising clk with rst_n=0, enter IDLE regardless of state, including mid-RUN, with any pending operation discarded.
REQ-022 SHALL reset busy=0, done=0, product_lo=0, product_hi=0, and accumulator, multiplicand, multiplier and counter to 0.
REQ-023 SHALL give reset priority over start on the same edge.

Configuration
REQ-024 SHALL use macro SHIFT_ADD_MUL_EARLY_EXIT_EN.
REQ-025 SHALL, without the macro, behave exactly as REQ-014/REQ-019.
REQ-026 SHALL, with the macro, also leave RUN for DONE on the edge where the post-shift multiplier is zero; latency = max(1, index of highest set bit of b + 1) edges; results identical to the fixed-latency build.

Structure
REQ-027 SHALL place XLEN, state encoding (2-bit enum) and counter width (6) in shared package mul_pkg.
REQ-028 SHALL instantiate the existing bit_Adder (a, b, cin, sum, cout; 64-bit) twice for the 128-bit add; no other sub-module.
REQ-029 SHALL keep all registers in a single clk domain; outputs registered, no combinational path from start to done.

Verification
REQ-030 SHALL test a=5, b=0xA, start one cycle -> done after 64 edges, product_lo=0x32, product_hi=0, busy high for 65 cycles.
REQ-031 SHALL test a=b=0xFFFFFFFFFFFFFFFF -> product_hi=0xFFFFFFFFFFFFFFFE, product_lo=0x0000000000000001.
REQ-032 SHALL test a=0x1234567890ABCDEF, b=0xFEDCBA0987654321 -> product matches 128-bit reference model; start re-pulsed with other operands mid-RUN -> ignored, same result.
REQ-033 SHALL test rst_n=0 for one edge at step 30 -> next cycle busy=0, done=0, products 0; subsequent start a=3, b=7 -> product_lo=21.
REQ-034 SHALL test, with SHIFT_ADD_MUL_EARLY_EXIT_EN, a=0xFF, b=0 -> done after 1 edge, product 0; b=5 -> done after 3 edges, product_lo=0x4FB; without macro both take 64.
REQ-035 SHALL test back-to-back: start held high continuously -> operations complete every 66 cycles, done never high two consecutive cycles.
